// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, divisor helper, line defaults.
package uart_pkg;

    localparam int unsigned UART_BAUD       = 115200;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    // Rounded clocks-per-sample-tick divisor.
    function automatic int unsigned uart_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned rate;
        rate = baud * oversample;
        return (clk_hz + rate / 2) / rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; push accepted when full only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign data_out = empty ? '0 : mem[rd_ptr];

    // Storage array, written on accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: synchronizer, oversample tick, deframing FSM, byte FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = UART_BAUD,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          I_clk,
    input  logic                          I_rst,
    input  logic                          I_uart_rx,
    output logic [7:0]                    O_data,
    output logic                          O_valid,
    input  logic                          I_ready,
    output logic [$clog2(FIFO_DEPTH):0]   O_count,
    output logic                          O_frame_err,
    output logic                          O_overrun
);

    localparam int unsigned DIV   = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(DIV - 1);

    logic             rx_meta;
    logic             rx_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             mid;

    rx_state_e        state_q, state_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_d, push_q;
    logic             frame_err_d;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    // Two-flop synchronizer; idle-high reset value avoids a false start bit.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= I_uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_TOP) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_TOP);
    assign mid  = tick && (os_cnt_q == OS_MID);

    // Deframer state and datapath registers.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q     <= RX_IDLE;
            os_cnt_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            O_frame_err <= 1'b0;
            O_overrun   <= 1'b0;
        end else begin
            state_q     <= state_d;
            os_cnt_q    <= os_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            O_frame_err <= frame_err_d;
            O_overrun   <= push_q & fifo_full & ~pop;
        end
    end

    // Next-state: sample at mid-bit; STOP returns to IDLE at mid-stop so a
    // back-to-back start edge is not missed.
    always_comb begin
        state_d     = state_q;
        os_cnt_d    = os_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        if (tick && (state_q != RX_IDLE)) begin
            os_cnt_d = os_cnt_q + OS_W'(1);
        end
        unique case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d  = RX_START;
                    os_cnt_d = '0;
                end
            end
            RX_START: begin
                if (mid) begin
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d   = RX_DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            RX_DATA: begin
                if (mid) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (mid) begin
                    if (rx_s) begin
                        push_d  = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign O_valid = ~fifo_empty;
    assign pop     = O_valid & I_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (I_clk),
        .rst      (I_rst),
        .push     (push_q),
        .data_in  (shift_q),
        .pop      (pop),
        .data_out (O_data),
        .count    (O_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receive front end for the SoC serial port: oversamples the asynchronous `I_uart_rx` pin, deframes 8N1 characters, and buffers received bytes in a small FIFO. Software-facing logic drains the FIFO through a valid/ready handshake. The block is the receive counterpart of the SoC UART transmitter and runs in the PLL `clk0` domain (100 MHz).

## Interface
- `CLK_HZ`, 100000000, input clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s
- `OVERSAMPLE`, 16, sample ticks per bit; fixed power of two
- `FIFO_DEPTH`, 16, bytes of buffering; power of two, ≥2
- `I_clk`  input  1  system clock (`clk0`)
- `I_rst`  input  1  synchronous, active-high reset
- `I_uart_rx`  input  1  asynchronous serial line, idle high
- `O_data`  output  8  byte at FIFO head
- `O_valid`  output  1  FIFO non-empty; `O_data` is valid
- `I_ready`  input  1  consumer accepts head byte when `O_valid & I_ready`
- `O_count`  output  $clog2(FIFO_DEPTH)+1  bytes held
- `O_frame_err`  output  1  one-cycle pulse: stop bit sampled low
- `O_overrun`  output  1  one-cycle pulse: good byte dropped, FIFO full

## Operation
- Input: 2-FF synchronizer on `I_uart_rx`; all logic uses synchronized `rx_s`.
- Tick generator: divisor `DIV = round(CLK_HZ/(BAUD*OVERSAMPLE))` (54 at defaults); one-cycle `tick` every DIV clocks, free-running.
- Per-bit sample counter `os_cnt` (0..OVERSAMPLE-1) advances on `tick`; bits sampled at `os_cnt == OVERSAMPLE/2-1`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on `rx_s==0` → START, `os_cnt` cleared.
  - START: at mid-bit, `rx_s==1` → IDLE (glitch, nothing reported); `rx_s==0` → DATA, bit index 0.
  - DATA: sample one bit per bit period, LSB first, into shift register; after bit 7 → STOP.
  - STOP: mid-bit `rx_s==1` → push byte, IDLE; `rx_s==0` → pulse `O_frame_err`, discard byte, BREAK.
  - BREAK: wait for `rx_s==1`, then IDLE (long break yields exactly one `O_frame_err`).
- FIFO: first-word-fall-through; head on `O_data` whenever `O_valid`.
  - Push when not full, or full with simultaneous pop.
  - Push refused when full without pop: byte dropped, `O_overrun` pulses; stored bytes untouched.
  - Pop on `O_valid & I_ready`; `I_ready` with empty FIFO ignored.
  - Pointers wrap modulo FIFO_DEPTH; `O_count` = pushes − pops.

## Timing
- Reset (`I_rst` high at a clock edge): FSM IDLE, synchronizer flops to 1, counters 0, FIFO emptied; `O_valid=0`, `O_data=8'h00`, `O_count=0`, `O_frame_err=0`, `O_overrun=0` from the next cycle.
- Reset mid-frame aborts the frame; no partial byte, no error pulse; reception resumes on the next falling edge after release.
- Pin-to-FSM latency: 2 cycles (synchronizer).
- Push occurs in the cycle after stop-bit sample; `O_valid`/`O_count` update the following cycle (1-cycle registered).
- Pop: `O_data`/`O_count` reflect the pop on the next cycle.
- `O_frame_err`, `O_overrun` are registered, exactly 1 cycle wide.
- Back-to-back frames: a start bit immediately after stop mid-sample must be caught (IDLE re-entered half a bit early).

## Structure
- Shared package `uart_pkg`: FSM state encoding, `uart_div()` constant function, default `BAUD`/`OVERSAMPLE` constants (shared with the transmitter).
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; ports push/data_in/pop/data_out/count/full/empty) holds the buffer; synchronizer, tick generator and FSM stay in `uart_rx_fifo`.

## Test plan
- Send 0x55 then 0xA3 at 115200 8N1, `I_ready=0` → `O_count=2`, `O_data=0x55`; pulse `I_ready` → `O_data=0xA3`, `O_count=1`.
- Low glitch of 3 µs (< half bit) on idle line → no push, no `O_frame_err`, FSM back in IDLE.
- Frame 0x7E with stop bit driven low, line held low 3 bit times → one `O_frame_err` pulse, `O_count` stays 0; next good 0x42 received normally.
- 17 bytes 0x00..0x10, `I_ready=0` → `O_count=16`, one `O_overrun` on 0x10; drain yields 0x00..0x0F in order.
- FIFO full, `I_ready=1` held while next byte completes → simultaneous push/pop, no overrun, `O_count` stays 16.
- `I_rst` asserted during DATA bit 4 of 0xFF → no byte, no error; following 0x31 received correctly.
